// File: rtl/parity_stream_checker_if.sv
`default_nettype none
// ============================================================================
// parity_stream_checker_if : input/output stream handshake bundle
// Revision 1.0
// ============================================================================
interface parity_stream_checker_if #(
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_parity;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_parity;
   logic              out_err;

   modport master (
      output in_valid, in_data, in_parity, out_ready,
      input  in_ready, out_valid, out_data, out_parity, out_err
   );

   modport slave (
      input  in_valid, in_data, in_parity, out_ready,
      output in_ready, out_valid, out_data, out_parity, out_err
   );
endinterface
`default_nettype wire

// File: rtl/parity_stream_checker.sv
`default_nettype none
// ============================================================================
// parity_stream_checker : per-word parity check, 2-entry skid buffer, error stats
// Revision 1.0
// ============================================================================
module parity_stream_checker #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       parity_type,
   input  logic             clr_err,
   output logic [CNT_W-1:0] err_count,
   output logic             err_sticky,
   parity_stream_checker_if.slave bus
);
   localparam logic [1:0]       MODE_NONE = 2'b00;
   localparam logic [1:0]       MODE_ODD  = 2'b01;
   localparam logic [1:0]       MODE_EVEN = 2'b10;
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   logic              m_valid;
   logic [DATA_W-1:0] m_data;
   logic              m_par;
   logic              m_err;
   logic              s_valid;
   logic [DATA_W-1:0] s_data;
   logic              s_par;
   logic              s_err;
   logic              in_ready_q;

   logic              exp_par;
   logic              word_err;
   logic              accept;
   logic              emit;
   logic              load_m;
   logic              load_s;
   logic              move_s;
   logic              s_valid_next;
   logic [CNT_W-1:0]  cnt_base;
   logic [CNT_W-1:0]  cnt_next;

   always_comb begin
      exp_par = 1'b1;
      case (parity_type)
         MODE_ODD:  exp_par = ~(^bus.in_data);
         MODE_EVEN: exp_par = ^bus.in_data;
         default:   exp_par = 1'b1;
      endcase
      word_err = (parity_type != MODE_NONE) && (bus.in_parity != exp_par);
   end

   assign accept = bus.in_valid & in_ready_q;
   assign emit   = m_valid & bus.out_ready;

   // S only ever fills while M is stalled; in_ready is low whenever S is full,
   // so a refill of M from S never coincides with an accept.
   assign load_m       = accept & (~m_valid | (emit & ~s_valid));
   assign load_s       = accept & m_valid & ~emit;
   assign move_s       = emit & s_valid;
   assign s_valid_next = load_s | (s_valid & ~move_s);

   always_ff @(posedge clk) begin
      if (!reset) begin
         m_valid    <= 1'b0;
         m_data     <= '0;
         m_par      <= 1'b1;
         m_err      <= 1'b0;
         s_valid    <= 1'b0;
         s_data     <= '0;
         s_par      <= 1'b1;
         s_err      <= 1'b0;
         in_ready_q <= 1'b1;
      end else begin
         if (load_m) begin
            m_valid <= 1'b1;
            m_data  <= bus.in_data;
            m_par   <= exp_par;
            m_err   <= word_err;
         end else if (move_s) begin
            m_valid <= 1'b1;
            m_data  <= s_data;
            m_par   <= s_par;
            m_err   <= s_err;
         end else if (emit) begin
            m_valid <= 1'b0;
         end

         if (load_s) begin
            s_data <= bus.in_data;
            s_par  <= exp_par;
            s_err  <= word_err;
         end
         s_valid    <= s_valid_next;
         in_ready_q <= ~s_valid_next;
      end
   end

   // Clear takes effect before a same-cycle error is counted.
   assign cnt_base = clr_err ? '0 : err_count;
   assign cnt_next = (accept && word_err && (cnt_base != CNT_MAX))
                     ? cnt_base + CNT_W'(1) : cnt_base;

   always_ff @(posedge clk) begin
      if (!reset) begin
         err_count  <= '0;
         err_sticky <= 1'b0;
      end else begin
         err_count  <= cnt_next;
         err_sticky <= (err_sticky & ~clr_err) | (accept & word_err);
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.out_valid  = m_valid;
   assign bus.out_data   = m_data;
   assign bus.out_parity = m_par;
   assign bus.out_err    = m_err;
endmodule
`default_nettype wire

// File: tb/tb_parity_stream_checker.sv
`default_nettype none
// ============================================================================
// tb_parity_stream_checker : directed and randomized checks against a FIFO model
// Revision 1.0
// ============================================================================
module tb_parity_stream_checker;
   localparam int DW   = 8;
   localparam int CW   = 2;
   localparam int MAXC = (1 << CW) - 1;

   typedef struct packed {
      logic [DW-1:0] d;
      logic          p;
      logic          e;
   } word_t;

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    parity_type;
   logic          clr_err;
   logic [CW-1:0] err_count;
   logic          err_sticky;

   parity_stream_checker_if #(.DATA_W(DW)) bus ();

   parity_stream_checker #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk         (clk),
      .reset       (reset),
      .parity_type (parity_type),
      .clr_err     (clr_err),
      .err_count   (err_count),
      .err_sticky  (err_sticky),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   int    n_chk  = 0;
   int    n_pass = 0;
   word_t q[$];
   int    m_cnt    = 0;
   logic  m_sticky = 1'b0;

   // Parity bit that makes the stated total-ones rule hold.
   function automatic logic ref_parity(logic [DW-1:0] d, logic [1:0] mode);
      int ones;
      ones = $countones(d);
      case (mode)
         2'b01:   return (ones % 2 == 0) ? 1'b1 : 1'b0;
         2'b10:   return (ones % 2 == 1) ? 1'b1 : 1'b0;
         default: return 1'b1;
      endcase
   endfunction

   // Predict the effect of the coming rising edge, then move to the next falling edge.
   task automatic tick();
      word_t w;
      word_t dropped;
      logic  acc;
      logic  emt;
      acc = bus.in_valid && (q.size() < 2);
      emt = (q.size() > 0) && bus.out_ready;
      if (!reset) begin
         q.delete();
         m_cnt    = 0;
         m_sticky = 1'b0;
      end else begin
         if (clr_err) begin
            m_cnt    = 0;
            m_sticky = 1'b0;
         end
         if (emt) dropped = q.pop_front();
         if (acc) begin
            w.d = bus.in_data;
            w.p = ref_parity(bus.in_data, parity_type);
            w.e = (parity_type != 2'b00) && (bus.in_parity != w.p);
            q.push_back(w);
            if (w.e) begin
               if (m_cnt < MAXC) m_cnt++;
               m_sticky = 1'b1;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic offer(logic [DW-1:0] d, logic p);
      bus.in_valid  = 1'b1;
      bus.in_data   = d;
      bus.in_parity = p;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick();
      tick();
      n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); else n_pass++;
      n_chk++; if (bus.out_parity !== 1'b1) $display("FAIL reset_out_parity got %b exp 1", bus.out_parity); else n_pass++;
      n_chk++; if (bus.out_data !== 8'h00) $display("FAIL reset_out_data got %h exp 00", bus.out_data); else n_pass++;
      n_chk++; if (bus.out_err !== 1'b0) $display("FAIL reset_out_err got %b exp 0", bus.out_err); else n_pass++;
      n_chk++; if (err_count !== 2'd0) $display("FAIL reset_err_count got %0d exp 0", err_count); else n_pass++;
      n_chk++; if (err_sticky !== 1'b0) $display("FAIL reset_sticky got %b exp 0", err_sticky); else n_pass++;
      n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); else n_pass++;
      reset = 1'b1;
   endtask

   task automatic test_odd();
      parity_type   = 2'b01;
      bus.out_ready = 1'b1;
      offer(8'hA5, 1'b1);
      tick();
      n_chk++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5) $display("FAIL odd_word got v=%b d=%h exp v=1 d=a5", bus.out_valid, bus.out_data); else n_pass++;
      n_chk++; if (bus.out_parity !== 1'b1 || bus.out_err !== 1'b0) $display("FAIL odd_good got p=%b e=%b exp p=1 e=0", bus.out_parity, bus.out_err); else n_pass++;
      offer(8'hA5, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      n_chk++; if (bus.out_err !== 1'b1) $display("FAIL odd_bad_err got %b exp 1", bus.out_err); else n_pass++;
      n_chk++; if (err_count !== 2'd1 || err_sticky !== 1'b1) $display("FAIL odd_stats got cnt=%0d st=%b exp cnt=1 st=1", err_count, err_sticky); else n_pass++;
      tick();
      n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL odd_drain got %b exp 0", bus.out_valid); else n_pass++;
   endtask

   task automatic test_even_stream();
      logic [DW-1:0] dv [3];
      logic          pv [3];
      logic          ev [3];
      dv = '{8'h01, 8'h03, 8'hFF};
      pv = '{1'b1, 1'b1, 1'b0};
      ev = '{1'b0, 1'b1, 1'b0};
      parity_type   = 2'b10;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         offer(dv[i], pv[i]);
         tick();
         n_chk++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== dv[i] || bus.out_err !== ev[i])
            $display("FAIL even_word%0d got v=%b d=%h e=%b exp v=1 d=%h e=%b", i, bus.out_valid, bus.out_data, bus.out_err, dv[i], ev[i]);
         else n_pass++;
      end
      bus.in_valid = 1'b0;
      tick();
      n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL even_drain got %b exp 0", bus.out_valid); else n_pass++;
      n_chk++; if (err_count !== CW'(m_cnt)) $display("FAIL even_err_count got %0d exp %0d", err_count, m_cnt); else n_pass++;
   endtask

   task automatic test_backpressure();
      parity_type   = 2'b01;
      bus.out_ready = 1'b0;
      offer(8'h11, 1'b1);
      tick();
      n_chk++; if (bus.in_ready !== 1'b1 || bus.out_data !== 8'h11) $display("FAIL bp_first got rdy=%b d=%h exp rdy=1 d=11", bus.in_ready, bus.out_data); else n_pass++;
      offer(8'h22, 1'b0);
      tick();
      n_chk++; if (bus.in_ready !== 1'b0 || bus.out_data !== 8'h11) $display("FAIL bp_second got rdy=%b d=%h exp rdy=0 d=11", bus.in_ready, bus.out_data); else n_pass++;
      offer(8'h33, 1'b0);
      tick();
      n_chk++; if (bus.in_ready !== 1'b0 || bus.out_data !== 8'h11 || bus.out_valid !== 1'b1) $display("FAIL bp_hold got rdy=%b v=%b d=%h exp rdy=0 v=1 d=11", bus.in_ready, bus.out_valid, bus.out_data); else n_pass++;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      n_chk++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h22 || bus.in_ready !== 1'b1) $display("FAIL bp_second_out got v=%b d=%h rdy=%b exp v=1 d=22 rdy=1", bus.out_valid, bus.out_data, bus.in_ready); else n_pass++;
      tick();
      n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL bp_no_dup got %b exp 0", bus.out_valid); else n_pass++;
   endtask

   task automatic test_saturation();
      parity_type   = 2'b11;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b0;
      clr_err       = 1'b1;
      tick();
      clr_err = 1'b0;
      n_chk++; if (err_count !== 2'd0 || err_sticky !== 1'b0) $display("FAIL sat_clear got cnt=%0d st=%b exp 0 0", err_count, err_sticky); else n_pass++;
      for (int i = 0; i < 5; i++) begin
         offer(8'(i), 1'b0);
         tick();
      end
      n_chk++; if (err_count !== 2'd3 || err_sticky !== 1'b1) $display("FAIL sat_hold got cnt=%0d st=%b exp 3 1", err_count, err_sticky); else n_pass++;
      clr_err = 1'b1;
      offer(8'h5A, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      n_chk++; if (err_count !== 2'd1 || err_sticky !== 1'b1) $display("FAIL sat_clr_same got cnt=%0d st=%b exp 1 1", err_count, err_sticky); else n_pass++;
      tick();
      clr_err = 1'b0;
      n_chk++; if (err_count !== 2'd0 || err_sticky !== 1'b0) $display("FAIL sat_clr_idle got cnt=%0d st=%b exp 0 0", err_count, err_sticky); else n_pass++;
   endtask

   task automatic test_none_and_reset();
      parity_type   = 2'b00;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         offer(8'($urandom), 1'($urandom));
         tick();
         n_chk++;
         if (bus.out_err !== 1'b0 || bus.out_parity !== 1'b1)
            $display("FAIL none_word%0d got e=%b p=%b exp e=0 p=1", i, bus.out_err, bus.out_parity);
         else n_pass++;
      end
      bus.out_ready = 1'b0;
      offer(8'hC3, 1'b0);
      tick();
      offer(8'h3C, 1'b1);
      tick();
      bus.in_valid = 1'b0;
      n_chk++; if (bus.in_ready !== 1'b0) $display("FAIL none_skid_full got %b exp 0", bus.in_ready); else n_pass++;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      n_chk++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_parity !== 1'b1 || bus.out_data !== 8'h00 || err_count !== 2'd0)
         $display("FAIL mid_reset got v=%b rdy=%b p=%b d=%h cnt=%0d exp v=0 rdy=1 p=1 d=00 cnt=0", bus.out_valid, bus.in_ready, bus.out_parity, bus.out_data, err_count);
      else n_pass++;
      bus.out_ready = 1'b1;
      tick();
      n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL mid_reset_dropped got %b exp 0", bus.out_valid); else n_pass++;
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.in_data   = 8'($urandom);
         bus.in_parity = 1'($urandom);
         bus.out_ready = ($urandom_range(0, 2) != 0);
         parity_type   = 2'($urandom);
         clr_err       = ($urandom_range(0, 15) == 0);
         tick();
         n_chk++;
         if (bus.out_valid !== (q.size() > 0) || bus.in_ready !== (q.size() < 2))
            $display("FAIL rnd_flow c%0d got v=%b rdy=%b exp v=%b rdy=%b", c, bus.out_valid, bus.in_ready, q.size() > 0, q.size() < 2);
         else n_pass++;
         if (q.size() > 0) begin
            n_chk++;
            if (bus.out_data !== q[0].d || bus.out_parity !== q[0].p || bus.out_err !== q[0].e)
               $display("FAIL rnd_word c%0d got d=%h p=%b e=%b exp d=%h p=%b e=%b", c, bus.out_data, bus.out_parity, bus.out_err, q[0].d, q[0].p, q[0].e);
            else n_pass++;
         end
         n_chk++;
         if (err_count !== CW'(m_cnt) || err_sticky !== m_sticky)
            $display("FAIL rnd_stats c%0d got cnt=%0d st=%b exp cnt=%0d st=%b", c, err_count, err_sticky, m_cnt, m_sticky);
         else n_pass++;
      end
      bus.in_valid = 1'b0;
      clr_err      = 1'b0;
   endtask

   initial begin
      reset         = 1'b0;
      parity_type   = 2'b00;
      clr_err       = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_parity = 1'b0;
      bus.out_ready = 1'b0;
      test_reset();
      test_odd();
      test_even_stream();
      test_backpressure();
      test_saturation();
      test_none_and_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
`default_nettype wire
